// File: rtl/eth_payload_extract_if.sv
// Byte stream from the payload extractor to its consumer; valid/ready handshake,
// the producer holds data stable until ready is seen.
interface eth_payload_extract_if;
   logic [7:0] byte_data;
   logic       byte_last;
   logic       byte_valid;
   logic       byte_ready;

   modport master (output byte_data, byte_last, byte_valid, input byte_ready);
   modport slave  (input byte_data, byte_last, byte_valid, output byte_ready);
endinterface

// File: rtl/eth_payload_extract.sv
// Packs payload nibbles (low first) into bytes and queues them in a show-ahead FIFO: one held byte of latency,
// output visible the cycle after push. Backpressure fills the FIFO; an overflow drops the rest of the frame.
module eth_payload_extract #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                   eth_clk,
   input  logic                   rst_n,
   input  logic [3:0]             nibble,
   input  logic                   nibble_valid,
   input  logic                   nibble_user_data,
   eth_payload_extract_if.master  byte_out,
   output logic [DEPTH_LOG2:0]    fifo_level,
   output logic                   err_overflow,
   output logic                   err_odd,
   output logic [15:0]            frame_cnt
);
   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef logic [DEPTH_LOG2-1:0] ptr_t;
   typedef logic [DEPTH_LOG2:0]   lvl_t;
   typedef enum logic [1:0] {IDLE, LO, HI, DISCARD} state_t;

   localparam lvl_t DEPTH_LVL = lvl_t'(DEPTH);

   logic [1:0] rst_sync_q;
   logic       rst_int_n;

   state_t      state_q, state_d;
   logic [3:0]  lo_nib_q, lo_nib_d;
   logic [7:0]  held_q, held_d;
   logic        held_vld_q, held_vld_d;
   logic        armed_q, armed_d;
   logic        err_odd_q, err_odd_d;
   logic        err_ovf_q, err_ovf_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   ptr_t        wr_ptr_q, wr_ptr_d;
   ptr_t        rd_ptr_q, rd_ptr_d;
   lvl_t        level_q, level_d;
   logic [8:0]  mem_q [DEPTH];

   logic        payload;
   logic        fifo_empty;
   logic        fifo_full;
   logic        pop;
   logic        push_req;
   logic        push_ok;
   logic [8:0]  push_word;
   logic [8:0]  head;

   // Reset asserts immediately but releases only on a clock edge.
   always_ff @(posedge eth_clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_int_n = rst_sync_q[1];

   assign payload    = nibble_valid & nibble_user_data;
   assign fifo_empty = (level_q == '0);
   assign fifo_full  = (level_q == DEPTH_LVL);
   assign pop        = ~fifo_empty & byte_out.byte_ready;
   assign head       = mem_q[rd_ptr_q];

   always_comb begin
      state_d     = state_q;
      lo_nib_d    = lo_nib_q;
      held_d      = held_q;
      held_vld_d  = held_vld_q;
      // Armed once a non-payload cycle is seen, so a region cut by reset is never resumed.
      armed_d     = armed_q | ~payload;
      err_odd_d   = 1'b0;
      err_ovf_d   = 1'b0;
      push_req    = 1'b0;
      push_word   = '0;
      frame_cnt_d = frame_cnt_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;

      case (state_q)
         IDLE: begin
            if (payload && armed_q) begin
               lo_nib_d = nibble;
               state_d  = HI;
            end
         end
         HI: begin
            if (payload) begin
               if (held_vld_q) begin
                  push_req  = 1'b1;
                  push_word = {1'b0, held_q};
               end
               held_d     = {nibble, lo_nib_q};
               held_vld_d = 1'b1;
               state_d    = LO;
            end else begin
               if (held_vld_q) begin
                  push_req  = 1'b1;
                  push_word = {1'b1, held_q};
               end
               held_vld_d = 1'b0;
               err_odd_d  = 1'b1;
               state_d    = IDLE;
            end
         end
         LO: begin
            if (payload) begin
               lo_nib_d = nibble;
               state_d  = HI;
            end else begin
               if (held_vld_q) begin
                  push_req  = 1'b1;
                  push_word = {1'b1, held_q};
               end
               held_vld_d = 1'b0;
               state_d    = IDLE;
            end
         end
         DISCARD: begin
            if (!nibble_valid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A pop on the same edge frees the slot, so a full FIFO can still accept.
      push_ok = push_req & (~fifo_full | pop);
      if (push_req && !push_ok) begin
         err_ovf_d  = 1'b1;
         held_vld_d = 1'b0;
         state_d    = DISCARD;
      end

      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + ptr_t'(1);
         if (push_word[8]) frame_cnt_d = frame_cnt_q + 16'd1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + ptr_t'(1);

      case ({push_ok, pop})
         2'b10:   level_d = level_q + lvl_t'(1);
         2'b01:   level_d = level_q - lvl_t'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge eth_clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q     <= IDLE;
         lo_nib_q    <= '0;
         held_q      <= '0;
         held_vld_q  <= 1'b0;
         armed_q     <= 1'b0;
         err_odd_q   <= 1'b0;
         err_ovf_q   <= 1'b0;
         frame_cnt_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
      end else begin
         state_q     <= state_d;
         lo_nib_q    <= lo_nib_d;
         held_q      <= held_d;
         held_vld_q  <= held_vld_d;
         armed_q     <= armed_d;
         err_odd_q   <= err_odd_d;
         err_ovf_q   <= err_ovf_d;
         frame_cnt_q <= frame_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
      end
   end

   always_ff @(posedge eth_clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_word;
   end

   assign byte_out.byte_valid = ~fifo_empty;
   assign byte_out.byte_data  = fifo_empty ? 8'h00 : head[7:0];
   assign byte_out.byte_last  = ~fifo_empty & head[8];
   assign fifo_level          = level_q;
   assign err_overflow        = err_ovf_q;
   assign err_odd             = err_odd_q;
   assign frame_cnt           = frame_cnt_q;
endmodule

// File: tb/tb_eth_payload_extract.sv
// Directed bench for eth_payload_extract: each scenario task drives nibbles and
// checks popped bytes, FIFO level, error pulses and the frame counter.
module tb_eth_payload_extract;
   logic        eth_clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  nibble = 4'h0;
   logic        nibble_valid = 1'b0;
   logic        nibble_user_data = 1'b0;
   logic [4:0]  fifo_level;
   logic        err_overflow;
   logic        err_odd;
   logic [15:0] frame_cnt;

   eth_payload_extract_if bs();

   eth_payload_extract #(.DEPTH_LOG2(4)) dut (
      .eth_clk          (eth_clk),
      .rst_n            (rst_n),
      .nibble           (nibble),
      .nibble_valid     (nibble_valid),
      .nibble_user_data (nibble_user_data),
      .byte_out         (bs),
      .fifo_level       (fifo_level),
      .err_overflow     (err_overflow),
      .err_odd          (err_odd),
      .frame_cnt        (frame_cnt)
   );

   int          n_checks = 0;
   int          n_pass = 0;
   int          ovf_pulses = 0;
   int          odd_pulses = 0;
   logic [15:0] exp_frames = 16'd0;
   logic [8:0]  got_q [$];

   always #5 eth_clk = ~eth_clk;

   // Pops happen on the next rising edge, so capture them half a cycle early.
   always @(negedge eth_clk) begin
      if (bs.byte_valid && bs.byte_ready) got_q.push_back({bs.byte_last, bs.byte_data});
   end

   task automatic tick();
      @(posedge eth_clk);
      #1;
      if (err_overflow) ovf_pulses++;
      if (err_odd) odd_pulses++;
   endtask

   task automatic send(input logic [3:0] v);
      nibble = v;
      nibble_valid = 1'b1;
      nibble_user_data = 1'b1;
      tick();
   endtask

   function automatic logic [7:0] ramp_byte(input int k);
      return {4'((2 * k + 1) % 16), 4'((2 * k) % 16)};
   endfunction

   function automatic logic [8:0] got_at(input int i);
      return (got_q.size() > i) ? got_q[i] : 9'h1FF;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      n_checks++; if (bs.byte_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bs.byte_valid); else n_pass++;
      n_checks++; if (bs.byte_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", bs.byte_data); else n_pass++;
      n_checks++; if (bs.byte_last !== 1'b0) $display("FAIL reset_last: got %b expected 0", bs.byte_last); else n_pass++;
      n_checks++; if (fifo_level !== 5'd0) $display("FAIL reset_level: got %0d expected 0", fifo_level); else n_pass++;
      n_checks++; if (err_overflow !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", err_overflow); else n_pass++;
      n_checks++; if (err_odd !== 1'b0) $display("FAIL reset_odd: got %b expected 0", err_odd); else n_pass++;
      n_checks++; if (frame_cnt !== 16'h0000) $display("FAIL reset_frame_cnt: got %h expected 0000", frame_cnt); else n_pass++;
      rst_n = 1'b1;
      repeat (3) tick();
      n_checks++; if (bs.byte_valid !== 1'b0) $display("FAIL post_reset_valid: got %b expected 0", bs.byte_valid); else n_pass++;
   endtask

   task automatic test_basic();
      bs.byte_ready = 1'b1;
      got_q.delete();
      send(4'h4); send(4'h3); send(4'h2); send(4'h1);
      n_checks++; if (bs.byte_valid !== 1'b1 || bs.byte_data !== 8'h34)
         $display("FAIL basic_show_ahead: got valid %b data %h expected 1 34", bs.byte_valid, bs.byte_data); else n_pass++;
      nibble_user_data = 1'b0;
      tick();
      nibble_valid = 1'b0;
      repeat (3) tick();
      exp_frames++;
      n_checks++; if (got_q.size() !== 2) $display("FAIL basic_count: got %0d expected 2", got_q.size()); else n_pass++;
      n_checks++; if (got_at(0) !== 9'h034) $display("FAIL basic_byte0: got %h expected 034", got_at(0)); else n_pass++;
      n_checks++; if (got_at(1) !== 9'h112) $display("FAIL basic_byte1: got %h expected 112", got_at(1)); else n_pass++;
      n_checks++; if (frame_cnt !== exp_frames) $display("FAIL basic_frame_cnt: got %h expected %h", frame_cnt, exp_frames); else n_pass++;
   endtask

   task automatic test_odd();
      bs.byte_ready = 1'b1;
      got_q.delete();
      odd_pulses = 0;
      send(4'hA); send(4'hB); send(4'hC);
      nibble_user_data = 1'b0;
      tick();
      n_checks++; if (err_odd !== 1'b1) $display("FAIL odd_pulse_high: got %b expected 1", err_odd); else n_pass++;
      nibble_valid = 1'b0;
      tick();
      n_checks++; if (err_odd !== 1'b0) $display("FAIL odd_pulse_low: got %b expected 0", err_odd); else n_pass++;
      repeat (3) tick();
      exp_frames++;
      n_checks++; if (odd_pulses !== 1) $display("FAIL odd_pulse_count: got %0d expected 1", odd_pulses); else n_pass++;
      n_checks++; if (got_q.size() !== 1 || got_at(0) !== 9'h1BA)
         $display("FAIL odd_byte: got %0d bytes first %h expected 1 bytes 1BA", got_q.size(), got_at(0)); else n_pass++;
      n_checks++; if (frame_cnt !== exp_frames) $display("FAIL odd_frame_cnt: got %h expected %h", frame_cnt, exp_frames); else n_pass++;
   endtask

   task automatic test_single();
      bs.byte_ready = 1'b1;
      got_q.delete();
      odd_pulses = 0;
      send(4'h5);
      nibble_user_data = 1'b0;
      tick();
      n_checks++; if (err_odd !== 1'b1) $display("FAIL single_odd: got %b expected 1", err_odd); else n_pass++;
      nibble_valid = 1'b0;
      repeat (3) tick();
      n_checks++; if (odd_pulses !== 1) $display("FAIL single_pulse_count: got %0d expected 1", odd_pulses); else n_pass++;
      n_checks++; if (got_q.size() !== 0) $display("FAIL single_no_byte: got %0d expected 0", got_q.size()); else n_pass++;
      n_checks++; if (frame_cnt !== exp_frames) $display("FAIL single_frame_cnt: got %h expected %h", frame_cnt, exp_frames); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [8:0] exp [5];
      int         max_lvl;
      int         bad;
      exp[0] = 9'h010; exp[1] = 9'h032; exp[2] = 9'h054; exp[3] = 9'h176; exp[4] = 9'h189;
      bs.byte_ready = 1'b1;
      got_q.delete();
      max_lvl = 0;
      for (int i = 0; i < 8; i++) begin
         send(4'(i));
         if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      end
      // A user_data gap inside one frame closes the first region.
      nibble_user_data = 1'b0;
      tick();
      send(4'h9); send(4'h8);
      nibble_valid = 1'b0;
      repeat (3) tick();
      exp_frames = exp_frames + 16'd2;
      bad = 0;
      for (int i = 0; i < 5; i++) if (got_at(i) !== exp[i]) bad++;
      n_checks++; if (got_q.size() !== 5) $display("FAIL b2b_count: got %0d expected 5", got_q.size()); else n_pass++;
      n_checks++; if (bad !== 0) $display("FAIL b2b_bytes: got %0d wrong bytes expected 0", bad); else n_pass++;
      n_checks++; if (max_lvl > 1) $display("FAIL b2b_no_buildup: got level %0d expected at most 1", max_lvl); else n_pass++;
      n_checks++; if (frame_cnt !== exp_frames) $display("FAIL b2b_frame_cnt: got %h expected %h", frame_cnt, exp_frames); else n_pass++;
   endtask

   task automatic test_full_pop();
      int bad;
      bs.byte_ready = 1'b0;
      got_q.delete();
      ovf_pulses = 0;
      for (int i = 0; i < 35; i++) send(4'(i % 16));
      n_checks++; if (fifo_level !== 5'd16) $display("FAIL fullpop_filled: got %0d expected 16", fifo_level); else n_pass++;
      bs.byte_ready = 1'b1;
      send(4'(35 % 16));
      n_checks++; if (fifo_level !== 5'd16) $display("FAIL fullpop_level: got %0d expected 16", fifo_level); else n_pass++;
      nibble_user_data = 1'b0;
      tick();
      nibble_valid = 1'b0;
      repeat (20) tick();
      exp_frames++;
      bad = 0;
      for (int k = 0; k < 18; k++) if (got_at(k) !== {k == 17, ramp_byte(k)}) bad++;
      n_checks++; if (ovf_pulses !== 0) $display("FAIL fullpop_no_ovf: got %0d pulses expected 0", ovf_pulses); else n_pass++;
      n_checks++; if (got_q.size() !== 18) $display("FAIL fullpop_count: got %0d expected 18", got_q.size()); else n_pass++;
      n_checks++; if (bad !== 0) $display("FAIL fullpop_bytes: got %0d wrong bytes expected 0", bad); else n_pass++;
      n_checks++; if (frame_cnt !== exp_frames) $display("FAIL fullpop_frame_cnt: got %h expected %h", frame_cnt, exp_frames); else n_pass++;
   endtask

   task automatic test_overflow();
      int bad;
      bs.byte_ready = 1'b0;
      got_q.delete();
      ovf_pulses = 0;
      for (int i = 0; i < 40; i++) send(4'(i % 16));
      nibble_valid = 1'b0;
      tick();
      tick();
      n_checks++; if (fifo_level !== 5'd16) $display("FAIL ovf_level: got %0d expected 16", fifo_level); else n_pass++;
      n_checks++; if (ovf_pulses !== 1) $display("FAIL ovf_pulses: got %0d expected 1", ovf_pulses); else n_pass++;
      n_checks++; if (frame_cnt !== exp_frames) $display("FAIL ovf_frame_cnt: got %h expected %h", frame_cnt, exp_frames); else n_pass++;
      bs.byte_ready = 1'b1;
      repeat (20) tick();
      bad = 0;
      for (int k = 0; k < 16; k++) if (got_at(k) !== {1'b0, ramp_byte(k)}) bad++;
      n_checks++; if (got_q.size() !== 16) $display("FAIL ovf_drain_count: got %0d expected 16", got_q.size()); else n_pass++;
      n_checks++; if (bad !== 0) $display("FAIL ovf_drain_bytes: got %0d wrong bytes expected 0", bad); else n_pass++;
      n_checks++; if (fifo_level !== 5'd0) $display("FAIL ovf_drained_level: got %0d expected 0", fifo_level); else n_pass++;
      send(4'h7); send(4'h8);
      nibble_user_data = 1'b0;
      tick();
      nibble_valid = 1'b0;
      repeat (3) tick();
      exp_frames++;
      n_checks++; if (got_q.size() !== 17 || got_at(16) !== 9'h187)
         $display("FAIL ovf_next_frame: got %0d bytes last %h expected 17 bytes 187", got_q.size(), got_at(16)); else n_pass++;
      n_checks++; if (frame_cnt !== exp_frames) $display("FAIL ovf_next_frame_cnt: got %h expected %h", frame_cnt, exp_frames); else n_pass++;
   endtask

   task automatic test_reset_mid();
      bs.byte_ready = 1'b0;
      got_q.delete();
      odd_pulses = 0;
      for (int i = 0; i < 8; i++) send(4'(i));
      n_checks++; if (fifo_level !== 5'd3) $display("FAIL rstmid_pre_level: got %0d expected 3", fifo_level); else n_pass++;
      nibble = 4'h8;
      rst_n = 1'b0;
      #1;
      n_checks++; if (bs.byte_valid !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", bs.byte_valid); else n_pass++;
      n_checks++; if (fifo_level !== 5'd0) $display("FAIL rstmid_level: got %0d expected 0", fifo_level); else n_pass++;
      tick();
      rst_n = 1'b1;
      exp_frames = 16'd0;
      for (int i = 9; i < 15; i++) send(4'(i));
      nibble_user_data = 1'b0;
      tick();
      nibble_valid = 1'b0;
      tick();
      bs.byte_ready = 1'b1;
      repeat (3) tick();
      n_checks++; if (got_q.size() !== 0) $display("FAIL rstmid_no_output: got %0d bytes expected 0", got_q.size()); else n_pass++;
      n_checks++; if (odd_pulses !== 0) $display("FAIL rstmid_no_odd: got %0d pulses expected 0", odd_pulses); else n_pass++;
      n_checks++; if (frame_cnt !== exp_frames) $display("FAIL rstmid_frame_cnt: got %h expected %h", frame_cnt, exp_frames); else n_pass++;
   endtask

   task automatic test_wrap();
      bs.byte_ready = 1'b1;
      got_q.delete();
      // Stand-in for 65534 prior frames.
      force dut.frame_cnt_q = 16'hFFFE;
      #2;
      release dut.frame_cnt_q;
      send(4'h1); send(4'h2);
      nibble_user_data = 1'b0;
      tick();
      nibble_valid = 1'b0;
      tick();
      n_checks++; if (frame_cnt !== 16'hFFFF) $display("FAIL wrap_ffff: got %h expected FFFF", frame_cnt); else n_pass++;
      send(4'h3); send(4'h4);
      nibble_user_data = 1'b0;
      tick();
      nibble_valid = 1'b0;
      repeat (3) tick();
      n_checks++; if (frame_cnt !== 16'h0000) $display("FAIL wrap_zero: got %h expected 0000", frame_cnt); else n_pass++;
      n_checks++; if (got_at(1) !== 9'h143) $display("FAIL wrap_byte: got %h expected 143", got_at(1)); else n_pass++;
   endtask

   initial begin
      bs.byte_ready = 1'b1;
      repeat (3) tick();
      test_reset();
      test_basic();
      test_odd();
      test_single();
      test_back_to_back();
      test_full_pop();
      test_overflow();
      test_reset_mid();
      test_wrap();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/eth_payload_extract.md
ETH_PAYLOAD_EXTRACT -- requirements
Module: eth_payload_extract

Interface
REQ-001 Parameter DEPTH_LOG2, default 4, SHALL set output FIFO depth to 2**DEPTH_LOG2 entries of {last, byte}.
REQ-002 eth_clk  in  1  sole clock; all logic SHALL be rising-edge eth_clk.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low; deassertion SHALL be synchronous to eth_clk.
REQ-004 nibble  in  4  receive nibble, sampled when nibble_valid=1.
REQ-005 nibble_valid  in  1  high for the duration of a frame; low = inter-frame gap.
REQ-006 nibble_user_data  in  1  marks nibbles belonging to the payload region; ignored when nibble_valid=0.
REQ-007 byte_data  out  8  FIFO head byte.
REQ-008 byte_last  out  1  FIFO head is final payload byte of its frame.
REQ-009 byte_valid  out  1  FIFO non-empty.
REQ-010 byte_ready  in  1  consumer accepts head when byte_valid & byte_ready.
REQ-011 fifo_level  out  DEPTH_LOG2+1  current FIFO occupancy.
REQ-012 err_overflow  out  1  one-cycle pulse on byte dropped due to full FIFO.
REQ-013 err_odd  out  1  one-cycle pulse on payload region ending with an unpaired nibble.
REQ-014 frame_cnt  out  16  count of payload regions closed with byte_last pushed; wraps 0xFFFF->0x0000.

Function
REQ-015 Payload nibble = cycle with nibble_valid=1 and nibble_user_data=1; region end = first cycle after a payload nibble where that condition is false.
REQ-016 Byte assembly SHALL be low nibble first: 1st payload nibble -> byte[3:0], 2nd -> byte[7:4].
REQ-017 FSM states: IDLE, LO (expect low nibble), HI (expect high nibble), DISCARD.
REQ-018 IDLE->HI on payload nibble (low nibble captured); HI->LO on payload nibble (byte complete); LO->HI on payload nibble; LO/HI->IDLE on region end.
REQ-019 A completed byte SHALL be held one stage; the held byte SHALL be pushed with last=0 on the edge that completes the next byte.
REQ-020 On region end from LO with a held byte: held byte pushed with last=1 on that edge; frame_cnt increments same edge.
REQ-021 On region end from HI: held byte (if any) pushed with last=1, partial nibble discarded, err_odd pulses the following cycle; frame_cnt increments only if a byte was pushed.
REQ-022 Region of exactly one nibble: nothing pushed, err_odd pulses, frame_cnt unchanged.
REQ-023 Push when FIFO full (level before edge = depth) and no simultaneous pop: byte dropped, err_overflow pulses next cycle, held byte cleared, FSM -> DISCARD.
REQ-024 Push with simultaneous pop at full SHALL be accepted (no overflow).
REQ-025 DISCARD ignores all nibbles; -> IDLE on first cycle with nibble_valid=0; no last byte pushed for that frame.
REQ-026 nibble_valid falling mid-payload SHALL be treated as region end (REQ-020/021).
REQ-027 A new payload region after a region end SHALL start fresh from IDLE; gaps with nibble_user_data=0 inside one frame create separate regions.
REQ-028 FIFO SHALL be show-ahead: a byte pushed on edge N drives byte_valid/byte_data on cycle N+1.
REQ-029 Pop on empty SHALL be ignored; fifo_level SHALL never exceed depth or underflow.
REQ-030 Throughput: one byte per two payload nibbles sustained with byte_ready=1, no bubbles introduced.

Reset
REQ-031 While rst_n=0: FSM=IDLE, FIFO empty, held byte invalid, byte_valid=0, byte_data=0, byte_last=0, fifo_level=0, err_overflow=0, err_odd=0, frame_cnt=0.
REQ-032 Reset mid-frame SHALL discard partial/held bytes and FIFO contents; after release, nibbles SHALL be ignored until next payload region start (FSM from IDLE).

Verification
REQ-033 Payload nibbles 4,3,2,1 then user_data=0, byte_ready=1 -> bytes 0x34 (last=0), 0x12 (last=1); frame_cnt=1.
REQ-034 Payload nibbles A,B,C (odd) -> one byte 0xBA last=1, err_odd one pulse, frame_cnt=1.
REQ-035 DEPTH_LOG2=4, byte_ready=0, 40 payload nibbles -> 16 bytes stored, fifo_level=16, err_overflow one pulse, frame_cnt=0, no last byte; next frame of 2 nibbles after draining -> one byte last=1.
REQ-036 Single payload nibble 0x5 -> no byte, err_odd pulse, frame_cnt unchanged.
REQ-037 rst_n low for 1 cycle after 3 pushed bytes mid-frame -> byte_valid=0, fifo_level=0 immediately; remaining nibbles of that region produce no output.
REQ-038 frame_cnt preloaded by 65535 two-nibble frames, one more -> frame_cnt=0x0000.
